// File: rtl/gpr_wport_arb_if.sv
// GPR write-port arbiter bundle: WB and MDU write requests, MDU issue tracking,
// hazard query and the arbitrated GPR write port.
interface gpr_wport_arb_if;
   logic        wb_we;
   logic [4:0]  wb_a;
   logic [31:0] wb_wd;
   logic        md_req;
   logic [4:0]  md_a;
   logic [31:0] md_wd;
   logic        md_gnt;
   logic        md_issue;
   logic [4:0]  md_issue_a;
   logic [4:0]  hz_a1;
   logic [4:0]  hz_a2;
   logic        hz_stall;
   logic        stall_wb;
   logic        gpr_we;
   logic [4:0]  gpr_a3;
   logic [31:0] gpr_wd;
   logic [31:0] busy;

   modport slave (
      input  wb_we, wb_a, wb_wd, md_req, md_a, md_wd, md_issue, md_issue_a, hz_a1, hz_a2,
      output md_gnt, hz_stall, stall_wb, gpr_we, gpr_a3, gpr_wd, busy
   );

   modport master (
      output wb_we, wb_a, wb_wd, md_req, md_a, md_wd, md_issue, md_issue_a, hz_a1, hz_a2,
      input  md_gnt, hz_stall, stall_wb, gpr_we, gpr_a3, gpr_wd, busy
   );
endinterface

// File: rtl/gpr_wport_arb.sv
// Shares the single GPR write port between WB (priority) and the MDU, stalls WB
// when the MDU starves, and tracks pending MDU destinations for hazard detection.
module gpr_wport_arb #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic             clk,
   input logic             reset,
   gpr_wport_arb_if.slave  bus
);

   typedef enum logic [1:0] {StIdle, StWait, StForce} state_e;

   localparam logic [3:0] LimitCnt = 4'(STARVE_LIMIT);

   state_e      state_q;
   logic [3:0]  wait_cnt_q;
   logic [3:0]  cnt_inc;
   logic        stall_q;
   logic        md_gnt;
   logic        lose;
   logic [31:0] busy_q;
   logic [31:0] busy_d;

   assign md_gnt = bus.md_req & ~bus.wb_we;
   assign lose   = bus.md_req & bus.wb_we;

   assign bus.md_gnt   = md_gnt;
   assign bus.gpr_we   = bus.wb_we | md_gnt;
   assign bus.gpr_a3   = bus.wb_we ? bus.wb_a : bus.md_a;
   assign bus.gpr_wd   = bus.wb_we ? bus.wb_wd : bus.md_wd;
   assign bus.stall_wb = stall_q;
   assign bus.busy     = busy_q;
   assign bus.hz_stall = busy_q[bus.hz_a1] | busy_q[bus.hz_a2];

   assign cnt_inc = (wait_cnt_q == 4'hf) ? 4'hf : wait_cnt_q + 4'd1;

   // stall_q mirrors state_q==StForce so stall_wb has no input-to-output path.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         wait_cnt_q <= 4'd0;
         stall_q    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (lose) begin
                  wait_cnt_q <= 4'd1;
                  if (LimitCnt == 4'd1) begin
                     state_q <= StForce;
                     stall_q <= 1'b1;
                  end else begin
                     state_q <= StWait;
                  end
               end else begin
                  wait_cnt_q <= 4'd0;
               end
            end
            StWait: begin
               if (md_gnt || !bus.md_req) begin
                  state_q    <= StIdle;
                  wait_cnt_q <= 4'd0;
               end else begin
                  wait_cnt_q <= cnt_inc;
                  if (cnt_inc == LimitCnt) begin
                     state_q <= StForce;
                     stall_q <= 1'b1;
                  end
               end
            end
            StForce: begin
               if (md_gnt || !bus.md_req) begin
                  state_q    <= StIdle;
                  wait_cnt_q <= 4'd0;
                  stall_q    <= 1'b0;
               end
            end
            default: begin
               state_q    <= StIdle;
               wait_cnt_q <= 4'd0;
               stall_q    <= 1'b0;
            end
         endcase
      end
   end

   // Clear first so a same-edge issue to the granted register wins.
   always_comb begin
      busy_d = busy_q;
      if (md_gnt) begin
         busy_d[bus.md_a] = 1'b0;
      end
      if (bus.md_issue && (bus.md_issue_a != 5'd0)) begin
         busy_d[bus.md_issue_a] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_q <= 32'd0;
      end else begin
         busy_q <= busy_d;
      end
   end

endmodule

// File: tb/tb_gpr_wport_arb.sv
// Directed bench: the driver queues hand-computed expectations per cycle and a
// negedge monitor drains and compares them against the DUT outputs.
module tb_gpr_wport_arb;

   typedef enum int {SGnt, SWe, SA3, SWd, SHz, SStall, SBusy} sig_e;
   typedef struct {
      string       name;
      sig_e        sig;
      logic [31:0] val;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad = 0;
   exp_t q[$];

   gpr_wport_arb_if bus ();

   gpr_wport_arb #(.STARVE_LIMIT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] actual(sig_e s);
      case (s)
         SGnt:    return {31'd0, bus.md_gnt};
         SWe:     return {31'd0, bus.gpr_we};
         SA3:     return {27'd0, bus.gpr_a3};
         SWd:     return bus.gpr_wd;
         SHz:     return {31'd0, bus.hz_stall};
         SStall:  return {31'd0, bus.stall_wb};
         default: return bus.busy;
      endcase
   endfunction

   task automatic expect_val(string name, sig_e s, logic [31:0] v);
      exp_t e;
      e.name = name;
      e.sig  = s;
      e.val  = v;
      q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.wb_we = 1'b0; bus.wb_a = 5'd0; bus.wb_wd = 32'd0;
      bus.md_req = 1'b0; bus.md_a = 5'd0; bus.md_wd = 32'd0;
      bus.md_issue = 1'b0; bus.md_issue_a = 5'd0;
      bus.hz_a1 = 5'd0; bus.hz_a2 = 5'd0;
   endtask

   // Monitor: compare every queued expectation at the falling edge.
   initial begin
      exp_t        e;
      logic [31:0] a;
      forever begin
         @(negedge clk);
         while (q.size() > 0) begin
            e = q.pop_front();
            a = actual(e.sig);
            total++;
            if (a !== e.val) begin
               bad++;
               $display("FAIL %s: got %h want %h", e.name, a, e.val);
            end
         end
      end
   end

   initial begin
      idle_inputs();
      // Reset held: state and busy cleared, combinational paths still live.
      step();
      expect_val("rst_busy", SBusy, 32'd0);
      expect_val("rst_stall", SStall, 32'd0);
      expect_val("rst_gnt_idle", SGnt, 32'd0);
      step();
      bus.md_req = 1'b1; bus.md_a = 5'd3; bus.md_wd = 32'h7;
      expect_val("rst_gnt", SGnt, 32'd1);
      expect_val("rst_a3", SA3, 32'd3);
      step();
      idle_inputs();
      reset = 1'b1;
      expect_val("post_rst_busy", SBusy, 32'd0);

      // Issue to r5, hazard, then MDU writeback clears it.
      step();
      bus.md_issue = 1'b1; bus.md_issue_a = 5'd5;
      step();
      bus.md_issue = 1'b0; bus.hz_a1 = 5'd5;
      expect_val("busy_r5", SBusy, 32'h20);
      expect_val("hz_r5", SHz, 32'd1);
      step();
      bus.md_req = 1'b1; bus.md_a = 5'd5; bus.md_wd = 32'h1234;
      expect_val("md_gnt", SGnt, 32'd1);
      expect_val("md_we", SWe, 32'd1);
      expect_val("md_a3", SA3, 32'd5);
      expect_val("md_wd", SWd, 32'h1234);
      step();
      bus.md_req = 1'b0;
      expect_val("busy_clr5", SBusy, 32'd0);
      expect_val("hz_clr5", SHz, 32'd0);

      // r9 pending, WB starves the MDU until the forced stall.
      step();
      bus.md_issue = 1'b1; bus.md_issue_a = 5'd9;
      step();
      bus.md_issue = 1'b0; bus.hz_a1 = 5'd0; bus.hz_a2 = 5'd9;
      expect_val("hz_r9", SHz, 32'd1);
      bus.md_req = 1'b1; bus.md_a = 5'd9; bus.md_wd = 32'h99;
      bus.wb_we = 1'b1; bus.wb_a = 5'd2; bus.wb_wd = 32'hAAAA;
      expect_val("wb_prio_gnt", SGnt, 32'd0);
      expect_val("wb_prio_a3", SA3, 32'd2);
      expect_val("wb_prio_wd", SWd, 32'hAAAA);
      expect_val("starve_c1", SStall, 32'd0);
      for (int c = 2; c <= 6; c++) begin
         step();
         expect_val($sformatf("starve_c%0d", c), SStall, (c >= 5) ? 32'd1 : 32'd0);
      end
      step();
      bus.wb_we = 1'b0;
      expect_val("force_gnt", SGnt, 32'd1);
      expect_val("force_a3", SA3, 32'd9);
      expect_val("force_stall_hold", SStall, 32'd1);
      step();
      bus.md_req = 1'b0;
      expect_val("force_release", SStall, 32'd0);
      expect_val("hz_clr9", SHz, 32'd0);

      // Same-edge set and clear of r7: set wins; r0 never marked.
      step();
      bus.md_issue = 1'b1; bus.md_issue_a = 5'd7;
      bus.md_req = 1'b1; bus.md_a = 5'd7; bus.md_wd = 32'h77;
      step();
      bus.md_req = 1'b0; bus.md_issue_a = 5'd0;
      expect_val("set_wins", SBusy, 32'h80);
      step();
      bus.md_issue = 1'b0;
      expect_val("r0_not_busy", SBusy, 32'h80);
      bus.md_req = 1'b1; bus.md_a = 5'd7;
      step();
      bus.md_req = 1'b0;
      expect_val("clr_r7", SBusy, 32'd0);

      // Reset in FORCE with r8/r9 pending, then re-arbitration from IDLE.
      bus.md_issue = 1'b1; bus.md_issue_a = 5'd8;
      step();
      bus.md_issue_a = 5'd9;
      step();
      bus.md_issue = 1'b0;
      expect_val("busy_300", SBusy, 32'h300);
      bus.md_req = 1'b1; bus.md_a = 5'd3; bus.wb_we = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         step();
      end
      expect_val("pre_rst_force", SStall, 32'd1);
      step();
      reset = 1'b0;
      expect_val("rst_mid_stall", SStall, 32'd0);
      expect_val("rst_mid_busy", SBusy, 32'd0);
      step();
      reset = 1'b1;
      expect_val("restart_c1", SStall, 32'd0);
      for (int c = 2; c <= 5; c++) begin
         step();
         expect_val($sformatf("restart_c%0d", c), SStall, (c == 5) ? 32'd1 : 32'd0);
      end
      step();
      bus.wb_we = 1'b0;
      expect_val("restart_gnt", SGnt, 32'd1);
      step();
      idle_inputs();
      expect_val("restart_release", SStall, 32'd0);

      step();
      step();
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
